fp_norm_pipe: RTL and testbench
===============================

FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

Interface
REQ-001 Parameter P_EW, default 5, exponent width in bits (range 3..8).
REQ-002 Parameter P_FW, default 16, fraction width in bits excluding carry bit (range 8..32).
REQ-003 clk_core  input  1  single clock, all state on rising edge.
REQ-004 rst_core  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  upstream operand valid.
REQ-006 o_ready  output  1  block can accept operand this cycle.
REQ-007 i_s  input  1  operand sign.
REQ-008 i_e  input  P_EW  operand biased exponent.
REQ-009 i_f  input  P_FW+1  operand fraction, bit P_FW is carry, format f2.(P_FW-1).
REQ-010 o_valid  output  1  normalized result valid.
REQ-011 i_ready  input  1  downstream accepts result this cycle.
REQ-012 o_b  output  1+P_EW+P_FW  result {sign, exponent, fraction}.
REQ-013 o_uflow, o_oflow  output  1 each  per-result status flags, present only under FP_NORM_STATUS_EN.

Function
REQ-014 Transfers SHALL occur on i_valid&o_ready (input) and o_valid&i_ready (output) only.
REQ-015 Pipeline SHALL be two registered stages: S1 captures operand plus leading-zero count and zero/carry flags; S2 holds shifted fraction and final exponent.
REQ-016 Latency SHALL be 2 cycles from input transfer to o_valid with i_ready held high; throughput 1 result/cycle.
REQ-017 S2 SHALL load when S2 empty or i_ready=1; S1 SHALL load when S1 empty or S1 advances; o_ready = S1 empty or S1 advances (combinational from i_ready, no combinational i_valid->o_ready path).
REQ-018 Under stall (o_valid=1, i_ready=0) o_b, o_valid and flags SHALL remain stable; no operand lost, duplicated or reordered.
REQ-019 lzc = number of leading zeros of i_f[P_FW-1:0], P_FW-1 when all zero.
REQ-020 Carry (i_f[P_FW]=1): fraction = i_f[P_FW:1]; exponent = i_e+1, saturating at all-ones (i_e all-ones stays all-ones, oflow=1).
REQ-021 No carry: fraction = i_f[P_FW-1:0] << lzc; exponent = i_e - lzc in P_EW+1 bits; borrow SHALL force exponent 0 (uflow=1).
REQ-022 i_f all zero SHALL force exponent 0 (uflow=0).
REQ-023 Final exponent 0 SHALL force sign 0 and fraction 0.
REQ-024 Simultaneous input and output transfer in the same cycle SHALL both complete.

Reset
REQ-025 rst_core high SHALL asynchronously clear both stage valids; o_valid=0, o_b=0, flags=0, o_ready=1 while asserted.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; first result after release corresponds to first operand accepted after release.

Configuration
REQ-027 Macro FP_NORM_STATUS_EN defined: o_uflow/o_oflow ports and their S2 registers exist, aligned with o_b.
REQ-028 FP_NORM_STATUS_EN undefined: ports and registers absent; o_b behaviour identical.

Verification (P_EW=5, P_FW=16, i_ready=1 unless stated)
REQ-029 i_s=1, i_e=0x0F, i_f=0x04000 -> 2 cycles later o_b=0x2E8000, uflow=0, oflow=0.
REQ-030 i_s=0, i_e=0x10, i_f=0x18000 -> o_b=0x11C000; i_e=0x1F, i_f=0x18000 -> o_b=0x1FC000, oflow=1.
REQ-031 i_s=1, i_e=0x02, i_f=0x00010 -> o_b=0x000000, uflow=1; i_f=0x00000, i_e=0x0A -> o_b=0x000000, uflow=0.
REQ-032 4 back-to-back operands, i_ready low cycles 3..5 -> o_ready low once both stages full, o_b stable during stall, 4 results in order, none lost.
REQ-033 rst_core pulsed while 2 operands in flight -> o_valid=0 immediately, neither result emerges, next operand returns correct result after 2 cycles.

Source files
------------

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - two-stage floating-point normalizer with valid/ready handshake
// Optional status flags o_uflow/o_oflow are built when FP_NORM_STATUS_EN is defined.
module fp_norm_pipe #(
    parameter int P_EW = 5,
    parameter int P_FW = 16
) (
    input  logic                 clk_core,
    input  logic                 rst_core,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_s,
    input  logic [P_EW-1:0]      i_e,
    input  logic [P_FW:0]        i_f,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [P_EW+P_FW:0]   o_b
`ifdef FP_NORM_STATUS_EN
    ,
    output logic                 o_uflow,
    output logic                 o_oflow
`endif
);

    localparam int LZW = $clog2(P_FW);
    // Wide enough to hold both i_e and lzc plus a borrow bit for any legal parameter pair.
    localparam int DW  = ((P_EW > LZW) ? P_EW : LZW) + 1;
    localparam logic [P_EW-1:0] E_ONE = P_EW'(1);

    logic [LZW-1:0]    in_lzc;
    logic              in_found;

    logic              s1_v;
    logic              s1_s;
    logic [P_EW-1:0]   s1_e;
    logic [P_FW:0]     s1_f;
    logic [LZW-1:0]    s1_lzc;
    logic              s1_zero;
    logic              s1_carry;

    logic              s2_v;
    logic [P_EW+P_FW:0] s2_b;

    logic              s2_en;
    logic              n_sign;
    logic [P_EW-1:0]   n_exp;
    logic [P_FW-1:0]   n_frac;
    logic [DW-1:0]     diff;
`ifdef FP_NORM_STATUS_EN
    logic              n_uflow;
    logic              n_oflow;
    logic              s2_uflow;
    logic              s2_oflow;
`endif

    // Leading-zero count of the fraction below the carry bit; all-zero saturates at P_FW-1.
    always_comb begin
        in_lzc   = LZW'(P_FW - 1);
        in_found = 1'b0;
        for (int i = P_FW - 1; i >= 0; i--) begin
            if (!in_found && i_f[i]) begin
                in_lzc   = LZW'(P_FW - 1 - i);
                in_found = 1'b1;
            end
        end
    end

    assign s2_en   = !s2_v || i_ready;
    assign o_ready = !s1_v || s2_en;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            s1_v     <= 1'b0;
            s1_s     <= 1'b0;
            s1_e     <= '0;
            s1_f     <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
            s1_carry <= 1'b0;
        end else if (o_ready) begin
            s1_v <= i_valid;
            if (i_valid) begin
                s1_s     <= i_s;
                s1_e     <= i_e;
                s1_f     <= i_f;
                s1_lzc   <= in_lzc;
                s1_zero  <= !in_found && !i_f[P_FW];
                s1_carry <= i_f[P_FW];
            end
        end
    end

    always_comb begin
        n_sign = s1_s;
        n_exp  = '0;
        n_frac = '0;
        diff   = DW'(s1_e) - DW'(s1_lzc);
`ifdef FP_NORM_STATUS_EN
        n_uflow = 1'b0;
        n_oflow = 1'b0;
`endif
        if (s1_carry) begin
            n_frac = s1_f[P_FW:1];
            n_exp  = (&s1_e) ? s1_e : s1_e + E_ONE;
`ifdef FP_NORM_STATUS_EN
            n_oflow = &s1_e;
`endif
        end else if (s1_zero) begin
            n_exp = '0;
        end else if (diff[DW-1:P_EW] != '0) begin
            // Any bit above the exponent field means lzc exceeded the exponent.
            n_exp = '0;
`ifdef FP_NORM_STATUS_EN
            n_uflow = 1'b1;
`endif
        end else begin
            n_frac = s1_f[P_FW-1:0] << s1_lzc;
            n_exp  = diff[P_EW-1:0];
        end
        if (n_exp == '0) begin
            n_sign = 1'b0;
            n_frac = '0;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            s2_v <= 1'b0;
            s2_b <= '0;
`ifdef FP_NORM_STATUS_EN
            s2_uflow <= 1'b0;
            s2_oflow <= 1'b0;
`endif
        end else if (s2_en) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_b <= {n_sign, n_exp, n_frac};
`ifdef FP_NORM_STATUS_EN
                s2_uflow <= n_uflow;
                s2_oflow <= n_oflow;
`endif
            end
        end
    end

    assign o_valid = s2_v;
    assign o_b     = s2_b;
`ifdef FP_NORM_STATUS_EN
    assign o_uflow = s2_uflow;
    assign o_oflow = s2_oflow;
`endif

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - directed vector bench for fp_norm_pipe (P_EW=5, P_FW=16)
module tb_fp_norm_pipe;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        i_valid;
    logic        o_ready;
    logic        i_s;
    logic [4:0]  i_e;
    logic [16:0] i_f;
    logic        o_valid;
    logic        i_ready;
    logic [21:0] o_b;
`ifdef FP_NORM_STATUS_EN
    logic        o_uflow;
    logic        o_oflow;
`endif

    fp_norm_pipe #(.P_EW(5), .P_FW(16)) dut (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_s      (i_s),
        .i_e      (i_e),
        .i_f      (i_f),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_b      (o_b)
`ifdef FP_NORM_STATUS_EN
        ,
        .o_uflow  (o_uflow),
        .o_oflow  (o_oflow)
`endif
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [16:0] f;
        logic [21:0] b;
        logic        uf;
        logic        of;
    } vec_t;

    vec_t        vecs [10];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          in_idx, out_idx, n_inflight;
    int          sel [4];
    logic        hold;
    logic [21:0] hold_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        i_s = v.s;
        i_e = v.e;
        i_f = v.f;
    endtask

    // Starts and ends at posedge+1; checks exact two-cycle latency of one operand.
    task automatic run_vec(input int k);
        drive(vecs[k]);
        i_valid = 1'b1;
        #3;
        chk($sformatf("v%0d_ready", k), o_ready, 1);
        @(posedge clk_core); #1;
        i_valid = 1'b0;
        chk($sformatf("v%0d_early", k), o_valid, 0);
        @(posedge clk_core); #1;
        chk($sformatf("v%0d_valid", k), o_valid, 1);
        chk($sformatf("v%0d_b", k), o_b, vecs[k].b);
`ifdef FP_NORM_STATUS_EN
        chk($sformatf("v%0d_uflow", k), o_uflow, vecs[k].uf);
        chk($sformatf("v%0d_oflow", k), o_oflow, vecs[k].of);
`endif
        @(posedge clk_core); #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'h0F, 17'h04000, 22'h2E8000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'h10, 17'h18000, 22'h11C000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'h1F, 17'h18000, 22'h1FC000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'h02, 17'h00010, 22'h000000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'h0A, 17'h00000, 22'h000000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'h05, 17'h08000, 22'h058000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 5'h02, 17'h02000, 22'h000000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 5'h03, 17'h02000, 22'h218000, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 5'h1E, 17'h1FFFF, 22'h3FFFFF, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 5'h1F, 17'h00001, 22'h108000, 1'b0, 1'b0};
        sel = '{0, 1, 5, 9};

        rst_core = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        drive(vecs[0]);
        @(posedge clk_core); #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_b", o_b, 0);
        chk("rst_ready", o_ready, 1);
`ifdef FP_NORM_STATUS_EN
        chk("rst_uflow", o_uflow, 0);
        chk("rst_oflow", o_oflow, 0);
`endif
        @(posedge clk_core); #1;
        rst_core = 1'b0;
        @(posedge clk_core); #1;

        for (int k = 0; k < 10; k++) run_vec(k);

        // Four back-to-back operands with the sink stalled in cycles 3..5.
        in_idx = 0; out_idx = 0; n_inflight = 0; hold = 1'b0; hold_b = '0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            i_ready = !(cyc >= 3 && cyc <= 5);
            if (in_idx < 4) begin
                drive(vecs[sel[in_idx]]);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk_core);
            chk($sformatf("stall_ready_c%0d", cyc), o_ready, ((n_inflight < 2) || i_ready));
            if (o_valid && !i_ready) begin
                if (hold) chk($sformatf("stall_hold_c%0d", cyc), o_b, hold_b);
                hold = 1'b1;
                hold_b = o_b;
            end else begin
                hold = 1'b0;
            end
            if (o_valid && i_ready) begin
                chk($sformatf("stall_out%0d", out_idx), o_b, vecs[sel[out_idx]].b);
                out_idx++;
                n_inflight--;
            end
            if (i_valid && o_ready) begin
                in_idx++;
                n_inflight++;
            end
            @(posedge clk_core); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("stall_count", out_idx, 4);
        chk("stall_drained", o_valid, 0);

        // Reset with two operands in flight.
        drive(vecs[0]);
        i_valid = 1'b1;
        @(posedge clk_core); #1;
        drive(vecs[1]);
        @(posedge clk_core); #1;
        i_valid = 1'b0;
        chk("mid_valid_pre", o_valid, 1);
        rst_core = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_b", o_b, 0);
        chk("mid_rst_ready", o_ready, 1);
        @(posedge clk_core); #1;
        rst_core = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_core); #1;
            chk($sformatf("mid_flush_c%0d", c), o_valid, 0);
        end
        run_vec(8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
